// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with a
// variable-latency unified memory, traps a stalled bus into ERR and counts retired instructions.
module multicycle_ctrl_fsm #(
    parameter int unsigned     OP_W        = 6,
    parameter logic [OP_W-1:0] ALU_OP_ADD  = 6'b001000,
    parameter logic [OP_W-1:0] ALU_OP_SUB  = 6'b000100,
    parameter int unsigned     MEM_TIMEOUT = 16,
    parameter int unsigned     CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OP_W-1:0]  instr_op_i,
    input  logic             mem_ready_i,
    input  logic             zero_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             mdr_write_o,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic [1:0]       pc_src_sel_o,
    output logic             alu_src1_sel_o,
    output logic [1:0]       alu_src2_sel_o,
    output logic [OP_W-1:0]  alu_op_o,
    output logic             reg_write_o,
    output logic             reg_w1_addr_sel_o,
    output logic             reg_w1_data_sel_o,
    output logic             instr_done_o,
    output logic             illegal_o,
    output logic             err_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count_o
);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

    // Counter only needs to reach MEM_TIMEOUT-1: the final wait cycle jumps to ERR.
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StRexe   = 4'd3,
        StRwb    = 4'd4,
        StIexe   = 4'd5,
        StIwb    = 4'd6,
        StMaddr  = 4'd7,
        StMrd    = 4'd8,
        StMwb    = 4'd9,
        StMwr    = 4'd10,
        StBranch = 4'd11,
        StJump   = 4'd12,
        StIll    = 4'd13,
        StErr    = 4'd15
    } state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (32'(wait_q) == MEM_TIMEOUT - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= '0;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        mem_req_o         = 1'b0;
        mem_we_o          = 1'b0;
        iord_o            = 1'b0;
        ir_write_o        = 1'b0;
        mdr_write_o       = 1'b0;
        pc_write_o        = 1'b0;
        pc_write_cond_o   = 1'b0;
        pc_src_sel_o      = 2'd0;
        alu_src1_sel_o    = 1'b0;
        alu_src2_sel_o    = 2'd0;
        alu_op_o          = '0;
        reg_write_o       = 1'b0;
        reg_w1_addr_sel_o = 1'b0;
        reg_w1_data_sel_o = 1'b0;
        instr_done_o      = 1'b0;
        illegal_o         = 1'b0;
        err_o             = 1'b0;

        case (state_q)
            StIdle: state_d = StFetch;

            StFetch: begin
                mem_req_o      = 1'b1;
                alu_src2_sel_o = 2'd1;
                alu_op_o       = ALU_OP_ADD;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = StDecode;
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end

            StDecode: begin
                // Speculative branch target PC + (imm << 2) lands in ALUOut.
                alu_src2_sel_o = 2'd3;
                alu_op_o       = ALU_OP_ADD;
                case (instr_op_i)
                    OP_R:           state_d = StRexe;
                    OP_ADDI, OP_ORI: state_d = StIexe;
                    OP_LW, OP_SW:   state_d = StMaddr;
                    OP_BEQ:         state_d = StBranch;
                    OP_J:           state_d = StJump;
                    default:        state_d = StIll;
                endcase
            end

            StRexe: begin
                alu_src1_sel_o = 1'b1;
                alu_src2_sel_o = 2'd0;
                alu_op_o       = op_q;
                state_d        = StRwb;
            end

            StRwb: begin
                reg_write_o       = 1'b1;
                reg_w1_addr_sel_o = 1'b1;
                instr_done_o      = 1'b1;
                state_d           = StFetch;
            end

            StIexe: begin
                alu_src1_sel_o = 1'b1;
                alu_src2_sel_o = 2'd2;
                alu_op_o       = op_q;
                state_d        = StIwb;
            end

            StIwb: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                state_d      = StFetch;
            end

            StMaddr: begin
                alu_src1_sel_o = 1'b1;
                alu_src2_sel_o = 2'd2;
                alu_op_o       = ALU_OP_ADD;
                state_d        = (op_q == OP_SW) ? StMwr : StMrd;
            end

            StMrd: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                if (mem_ready_i) begin
                    mdr_write_o = 1'b1;
                    state_d     = StMwb;
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end

            StMwb: begin
                reg_write_o       = 1'b1;
                reg_w1_data_sel_o = 1'b1;
                instr_done_o      = 1'b1;
                state_d           = StFetch;
            end

            StMwr: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
                if (mem_ready_i) begin
                    instr_done_o = 1'b1;
                    state_d      = StFetch;
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end

            StBranch: begin
                alu_src1_sel_o  = 1'b1;
                alu_src2_sel_o  = 2'd0;
                alu_op_o        = ALU_OP_SUB;
                pc_write_cond_o = 1'b1;
                pc_src_sel_o    = 2'd1;
                instr_done_o    = 1'b1;
                state_d         = StFetch;
            end

            StJump: begin
                pc_write_o   = 1'b1;
                pc_src_sel_o = 2'd2;
                instr_done_o = 1'b1;
                state_d      = StFetch;
            end

            StIll: begin
                illegal_o    = 1'b1;
                instr_done_o = 1'b1;
                state_d      = StFetch;
            end

            StErr: err_o = 1'b1;

            default: state_d = StIdle;
        endcase
    end

    // Opcode is held from DECODE so later states never depend on the IR staying put.
    always_comb begin
        op_d = op_q;
        if (state_q == StDecode) begin
            op_d = instr_op_i;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_req_o && !mem_ready_i && (wait_q != '1)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (instr_done_o) begin
            count_d = count_q + 1'b1;
        end
    end

    assign state_o       = state_q;
    assign instr_count_o = count_q;

endmodule
